// File: rtl/inst_rom_arbiter_pkg.sv
// Shared constants and helpers for the instruction-ROM arbiter and its
// future data-memory sibling.
package inst_rom_arbiter_pkg;

    localparam int          INST_ADDR_W    = 32;
    localparam int          INST_W         = 32;
    localparam int          DEFAULT_ADDR_W = 9;

    localparam logic [INST_W-1:0] ZERO_WORD    = 32'h0;
    localparam logic              CHIP_ENABLE  = 1'b1;
    localparam logic              CHIP_DISABLE = 1'b0;

    // A byte address is unusable when it is not word aligned or when it
    // points past the last word of a 2**aw-word ROM.
    function automatic logic addr_bad(input logic [INST_ADDR_W-1:0] addr,
                                      input int                     aw);
        logic [INST_ADDR_W-1:0] w_hi;
        w_hi     = addr >> (aw + 2);
        addr_bad = (addr[1:0] != 2'b00) || (w_hi != '0);
    endfunction

endpackage

// File: rtl/inst_rom_arbiter_arb_starve_counter.sv
// Saturating wait counter with clear; at_max flags that the waiting
// requester has been refused long enough and must win next.
module arb_starve_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] r_count;

    // Clear has priority over increment; increments stop at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_max = (r_count == CNT_MAX);

endmodule

// File: rtl/inst_rom_arbiter.sv
// Two-port arbiter in front of a combinational instruction ROM: fetch has
// fixed priority, debug is forced through after a bounded wait, and the
// ROM word comes back one cycle after the grant.
module inst_rom_arbiter
    import inst_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int MAX_WAIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [INST_ADDR_W-1:0] if_addr,
    output logic                   if_gnt,
    output logic                   if_rvalid,
    output logic [INST_W-1:0]      if_rdata,
    output logic                   if_err,
    input  logic                   dbg_req,
    input  logic [INST_ADDR_W-1:0] dbg_addr,
    output logic                   dbg_gnt,
    output logic                   dbg_rvalid,
    output logic [INST_W-1:0]      dbg_rdata,
    output logic                   dbg_err,
    output logic                   rom_ce,
    output logic [INST_ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0]      rom_inst
);

    logic                   w_force_dbg;
    logic                   w_at_max;
    logic                   w_if_gnt;
    logic                   w_dbg_gnt;
    logic                   w_any_gnt;
    logic [INST_ADDR_W-1:0] w_sel_addr;
    logic                   w_bad;
    logic                   w_rom_ce;
    logic [INST_W-1:0]      w_resp_data;

    logic                   r_if_rvalid;
    logic [INST_W-1:0]      r_if_rdata;
    logic                   r_if_err;
    logic                   r_dbg_rvalid;
    logic [INST_W-1:0]      r_dbg_rdata;
    logic                   r_dbg_err;

    // Counts how long a pending debug request has been refused.
    arb_starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (dbg_req && !w_dbg_gnt),
        .i_clr    (!dbg_req || w_dbg_gnt),
        .o_at_max (w_at_max)
    );

    // Grant selection; both grants are held low while reset is asserted.
    always_comb begin
        w_force_dbg = dbg_req && w_at_max;
        w_dbg_gnt   = rst && dbg_req && (!if_req || w_force_dbg);
        w_if_gnt    = rst && if_req && !w_dbg_gnt;
        w_any_gnt   = w_if_gnt || w_dbg_gnt;
    end

    // Route the granted address to the ROM unless it is misaligned or out of range.
    always_comb begin
        w_sel_addr  = w_dbg_gnt ? dbg_addr : if_addr;
        w_bad       = addr_bad(w_sel_addr, ADDR_W);
        w_rom_ce    = (w_any_gnt && !w_bad) ? CHIP_ENABLE : CHIP_DISABLE;
        w_resp_data = w_bad ? ZERO_WORD : rom_inst;
    end

    assign if_gnt   = w_if_gnt;
    assign dbg_gnt  = w_dbg_gnt;
    assign rom_ce   = w_rom_ce;
    assign rom_addr = w_rom_ce ? w_sel_addr : ZERO_WORD;

    // Capture the ROM word at the end of the grant cycle; the idle port keeps its last data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_rvalid  <= 1'b0;
            r_if_rdata   <= ZERO_WORD;
            r_if_err     <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_dbg_rdata  <= ZERO_WORD;
            r_dbg_err    <= 1'b0;
        end else begin
            r_if_rvalid  <= w_if_gnt;
            r_dbg_rvalid <= w_dbg_gnt;
            if (w_if_gnt) begin
                r_if_rdata <= w_resp_data;
                r_if_err   <= w_bad;
            end
            if (w_dbg_gnt) begin
                r_dbg_rdata <= w_resp_data;
                r_dbg_err   <= w_bad;
            end
        end
    end

    assign if_rvalid  = r_if_rvalid;
    assign if_rdata   = r_if_rdata;
    assign if_err     = r_if_err;
    assign dbg_rvalid = r_dbg_rvalid;
    assign dbg_rdata  = r_dbg_rdata;
    assign dbg_err    = r_dbg_err;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Directed bench for inst_rom_arbiter with a behavioural ROM holding
// word[i] = 32'h1000_0000 + i.
module tb_inst_rom_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        if_err;
   logic        dbg_req;
   logic [31:0] dbg_addr;
   logic        dbg_gnt;
   logic        dbg_rvalid;
   logic [31:0] dbg_rdata;
   logic        dbg_err;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [31:0] rom_inst;

   int errors;
   int checks;

   inst_rom_arbiter #(
      .ADDR_W   (9),
      .MAX_WAIT (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_gnt     (if_gnt),
      .if_rvalid  (if_rvalid),
      .if_rdata   (if_rdata),
      .if_err     (if_err),
      .dbg_req    (dbg_req),
      .dbg_addr   (dbg_addr),
      .dbg_gnt    (dbg_gnt),
      .dbg_rvalid (dbg_rvalid),
      .dbg_rdata  (dbg_rdata),
      .dbg_err    (dbg_err),
      .rom_ce     (rom_ce),
      .rom_addr   (rom_addr),
      .rom_inst   (rom_inst)
   );

   // Free-running 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural ROM: word index is rom_addr[10:2], reads 0 when disabled.
   assign rom_inst = rom_ce ? (32'h1000_0000 + {23'b0, rom_addr[10:2]}) : 32'h0;

   // One comparison point: counts the check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to 1 unit after the next rising edge, then let comb logic settle.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      rst      = 1'b0;
      if_req   = 1'b1;
      if_addr  = 32'h8;
      dbg_req  = 1'b1;
      dbg_addr = 32'h10;

      // Reset state, even with both requests raised.
      applyStimulus();
      #1;
      checkOutput("rst_if_gnt", {31'b0, if_gnt}, 32'h0);
      checkOutput("rst_dbg_gnt", {31'b0, dbg_gnt}, 32'h0);
      checkOutput("rst_rom_ce", {31'b0, rom_ce}, 32'h0);
      checkOutput("rst_rom_addr", rom_addr, 32'h0);
      checkOutput("rst_if_rvalid", {31'b0, if_rvalid}, 32'h0);
      checkOutput("rst_dbg_rvalid", {31'b0, dbg_rvalid}, 32'h0);
      checkOutput("rst_if_rdata", if_rdata, 32'h0);
      checkOutput("rst_wait_cnt", 32'(dut.u_starve.r_count), 32'h0);

      if_req  = 1'b0;
      dbg_req = 1'b0;
      applyStimulus();
      rst = 1'b1;
      applyStimulus();

      // Single fetch at 0x8.
      if_req  = 1'b1;
      if_addr = 32'h8;
      #1;
      checkOutput("f1_if_gnt", {31'b0, if_gnt}, 32'h1);
      checkOutput("f1_dbg_gnt", {31'b0, dbg_gnt}, 32'h0);
      checkOutput("f1_rom_ce", {31'b0, rom_ce}, 32'h1);
      checkOutput("f1_rom_addr", rom_addr, 32'h8);
      applyStimulus();
      if_req = 1'b0;
      checkOutput("f1_if_rvalid", {31'b0, if_rvalid}, 32'h1);
      checkOutput("f1_if_rdata", if_rdata, 32'h1000_0002);
      checkOutput("f1_if_err", {31'b0, if_err}, 32'h0);
      #1;
      checkOutput("idle_rom_ce", {31'b0, rom_ce}, 32'h0);
      checkOutput("idle_rom_addr", rom_addr, 32'h0);

      // Back-to-back fetch stream 0x0, 0x4, 0x8.
      applyStimulus();
      checkOutput("f1_rvalid_drop", {31'b0, if_rvalid}, 32'h0);
      checkOutput("f1_rdata_hold", if_rdata, 32'h1000_0002);
      if_req  = 1'b1;
      if_addr = 32'h0;
      applyStimulus();
      checkOutput("s0_rvalid", {31'b0, if_rvalid}, 32'h1);
      checkOutput("s0_rdata", if_rdata, 32'h1000_0000);
      if_addr = 32'h4;
      applyStimulus();
      checkOutput("s1_rvalid", {31'b0, if_rvalid}, 32'h1);
      checkOutput("s1_rdata", if_rdata, 32'h1000_0001);
      if_addr = 32'h8;
      applyStimulus();
      checkOutput("s2_rvalid", {31'b0, if_rvalid}, 32'h1);
      checkOutput("s2_rdata", if_rdata, 32'h1000_0002);
      if_req = 1'b0;
      applyStimulus();
      checkOutput("s_end_rvalid", {31'b0, if_rvalid}, 32'h0);

      // Starvation guard: continuous fetch, debug forced on the 5th request cycle.
      if_req   = 1'b1;
      if_addr  = 32'h0;
      dbg_req  = 1'b1;
      dbg_addr = 32'h10;
      for (int i = 1; i <= 4; i++) begin
         #1;
         checkOutput($sformatf("starve%0d_dbg_gnt", i), {31'b0, dbg_gnt}, 32'h0);
         checkOutput($sformatf("starve%0d_if_gnt", i), {31'b0, if_gnt}, 32'h1);
         applyStimulus();
      end
      #1;
      checkOutput("force_wait_cnt", 32'(dut.u_starve.r_count), 32'h4);
      checkOutput("force_dbg_gnt", {31'b0, dbg_gnt}, 32'h1);
      checkOutput("force_if_gnt", {31'b0, if_gnt}, 32'h0);
      checkOutput("force_rom_addr", rom_addr, 32'h10);
      applyStimulus();
      dbg_req = 1'b0;
      checkOutput("force_dbg_rvalid", {31'b0, dbg_rvalid}, 32'h1);
      checkOutput("force_dbg_rdata", dbg_rdata, 32'h1000_0004);
      checkOutput("force_dbg_err", {31'b0, dbg_err}, 32'h0);
      checkOutput("force_if_rvalid", {31'b0, if_rvalid}, 32'h0);
      checkOutput("force_wait_clr", 32'(dut.u_starve.r_count), 32'h0);
      #1;
      checkOutput("after_force_if_gnt", {31'b0, if_gnt}, 32'h1);
      applyStimulus();
      if_req = 1'b0;
      checkOutput("after_force_if_rvalid", {31'b0, if_rvalid}, 32'h1);

      // Debug alone: misaligned, out of range, then last valid word.
      dbg_req  = 1'b1;
      dbg_addr = 32'h6;
      #1;
      checkOutput("mis_dbg_gnt", {31'b0, dbg_gnt}, 32'h1);
      checkOutput("mis_rom_ce", {31'b0, rom_ce}, 32'h0);
      checkOutput("mis_rom_addr", rom_addr, 32'h0);
      applyStimulus();
      checkOutput("mis_dbg_rvalid", {31'b0, dbg_rvalid}, 32'h1);
      checkOutput("mis_dbg_err", {31'b0, dbg_err}, 32'h1);
      checkOutput("mis_dbg_rdata", dbg_rdata, 32'h0);
      dbg_addr = 32'h800;
      #1;
      checkOutput("oor_dbg_gnt", {31'b0, dbg_gnt}, 32'h1);
      checkOutput("oor_rom_ce", {31'b0, rom_ce}, 32'h0);
      applyStimulus();
      checkOutput("oor_dbg_rvalid", {31'b0, dbg_rvalid}, 32'h1);
      checkOutput("oor_dbg_err", {31'b0, dbg_err}, 32'h1);
      checkOutput("oor_dbg_rdata", dbg_rdata, 32'h0);
      checkOutput("oor_wait_cnt", 32'(dut.u_starve.r_count), 32'h0);
      dbg_addr = 32'h7FC;
      #1;
      checkOutput("top_dbg_gnt", {31'b0, dbg_gnt}, 32'h1);
      checkOutput("top_rom_ce", {31'b0, rom_ce}, 32'h1);
      checkOutput("top_rom_addr", rom_addr, 32'h7FC);
      applyStimulus();
      dbg_req = 1'b0;
      checkOutput("top_dbg_rvalid", {31'b0, dbg_rvalid}, 32'h1);
      checkOutput("top_dbg_err", {31'b0, dbg_err}, 32'h0);
      checkOutput("top_dbg_rdata", dbg_rdata, 32'h1000_01FF);
      checkOutput("top_wait_cnt", 32'(dut.u_starve.r_count), 32'h0);

      // Asynchronous reset the cycle after a grant, with the wait counter non-zero.
      if_req   = 1'b1;
      if_addr  = 32'hC;
      dbg_req  = 1'b1;
      dbg_addr = 32'h0;
      applyStimulus();
      checkOutput("pre_rst_if_rvalid", {31'b0, if_rvalid}, 32'h1);
      checkOutput("pre_rst_if_rdata", if_rdata, 32'h1000_0003);
      checkOutput("pre_rst_wait_cnt", 32'(dut.u_starve.r_count), 32'h1);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_if_rvalid", {31'b0, if_rvalid}, 32'h0);
      checkOutput("async_if_rdata", if_rdata, 32'h0);
      checkOutput("async_wait_cnt", 32'(dut.u_starve.r_count), 32'h0);
      checkOutput("async_if_gnt", {31'b0, if_gnt}, 32'h0);
      checkOutput("async_rom_ce", {31'b0, rom_ce}, 32'h0);
      if_req  = 1'b0;
      dbg_req = 1'b0;
      applyStimulus();
      rst = 1'b1;
      applyStimulus();
      checkOutput("post_rst_if_rvalid", {31'b0, if_rvalid}, 32'h0);
      checkOutput("post_rst_dbg_rvalid", {31'b0, dbg_rvalid}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/inst_rom_arbiter.md
Name: inst_rom_arbiter

Overview:
Shares the single combinational instruction-ROM read port between two requesters: the instruction-fetch stage (if_*) and the debug/boot read port (dbg_*). Fetch has fixed priority. A starvation guard forces a debug grant after a bounded wait. The ROM word is captured in the grant cycle and returned one cycle later with a valid strobe. Misaligned and out-of-range addresses get an error response and never drive the ROM.

Parameters:
ADDR_W, 9, word-index width of the ROM (depth = 2**ADDR_W words); the ROM is indexed by addr[ADDR_W+1:2]
MAX_WAIT, 4, cycles dbg_req may be refused before it is forced to win; 0 = debug strict priority

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
if_req  in  1  fetch request; held with if_addr stable until if_gnt
if_addr  in  32  fetch byte address
if_gnt  out  1  combinational accept of the fetch request this cycle
if_rvalid  out  1  fetch response valid, one cycle after if_gnt
if_rdata  out  32  fetch instruction word
if_err  out  1  fetch response error (qualified by if_rvalid)
dbg_req  in  1  debug request; held with dbg_addr stable until dbg_gnt
dbg_addr  in  32  debug byte address
dbg_gnt  out  1  combinational accept of the debug request
dbg_rvalid  out  1  debug response valid, one cycle after dbg_gnt
dbg_rdata  out  32  debug read word
dbg_err  out  1  debug response error (qualified by dbg_rvalid)
rom_ce  out  1  ROM chip enable
rom_addr  out  32  ROM byte address (granted address, else 0)
rom_inst  in  32  ROM read word, combinational from rom_ce/rom_addr

Behaviour:
- Reset (rst=0, any time, asynchronous): registered state is cleared.
  - if_rvalid, dbg_rvalid, if_err, dbg_err = 0; if_rdata, dbg_rdata = 0; wait_cnt = 0.
  - A response pending at reset assertion is dropped.
  - Combinational outputs during reset: if_gnt = dbg_gnt = 0, rom_ce = 0, rom_addr = 0.
- Grant (combinational, cycle N):
  - force_dbg = dbg_req && (wait_cnt == MAX_WAIT).
  - dbg_gnt = dbg_req && (!if_req || force_dbg).
  - if_gnt = if_req && !dbg_gnt.
  - At most one grant per cycle. A grant can be given every cycle (back-to-back, no bubble).
- Address check on the granted address A:
  - bad = (A[1:0] != 0) || (A[31:ADDR_W+2] != 0).
- ROM drive:
  - rom_ce = any grant && !bad.
  - rom_addr = A when rom_ce, else 0.
  - No grant: rom_ce = 0, rom_addr = 0.
- Response (cycle N+1):
  - The granted port's rvalid = 1 for exactly one cycle.
  - rdata = rom_inst sampled at the end of cycle N, or 0 when bad.
  - err = bad.
  - The non-granted port's rvalid = 0 and its rdata/err hold their previous values.
- Starvation counter wait_cnt, width $clog2(MAX_WAIT+1) (minimum 1 bit):
  - dbg_req && !dbg_gnt: increment, saturating at MAX_WAIT.
  - dbg_gnt, or dbg_req == 0: cleared to 0.
  - Worst-case debug latency is therefore MAX_WAIT+1 cycles under continuous fetch.
- Simultaneous requests:
  - Fetch wins unless force_dbg.
  - On a forced debug grant, if_gnt = 0 and the fetch requester holds its request; it is granted next cycle.
- Requesters must not drop req or change addr before gnt; behaviour is undefined if they do.
- No internal FSM states beyond wait_cnt and the response registers. Latency is fixed at 1 cycle and there is no backpressure on responses.

Decomposition:
- Shared package:
  - ZERO_WORD = 32'h0
  - CHIP_ENABLE = 1'b1 and CHIP_DISABLE = 1'b0
  - INST_ADDR_W = 32 and INST_W = 32
  - default ADDR_W = 9
- One natural sub-module: arb_starve_counter (saturating counter with clear, parameter MAX_WAIT, output at_max). It is reusable for future data-memory arbitration.
- Grant, address check and response registers stay in the top.

Test Plan:
- Reset release; ROM preloaded with word[i] = 32'h1000_0000+i; if_req=1, if_addr=32'h8 -> if_gnt=1, rom_ce=1, rom_addr=32'h8 same cycle; next cycle if_rvalid=1, if_rdata=32'h1000_0002, if_err=0.
- Fetch streaming 0x0, 0x4, 0x8 on consecutive cycles -> if_rvalid high for 3 consecutive cycles with data ...0000, ...0001, ...0002; no bubble.
- if_req held high continuously; dbg_req=1, dbg_addr=32'h10, MAX_WAIT=4 -> dbg_gnt=1 exactly on the 5th request cycle; if_gnt=0 that cycle; next cycle dbg_rdata=32'h1000_0004; wait_cnt returns to 0.
- dbg_addr=32'h6 (misaligned), then 32'h800 (out of range, ADDR_W=9) -> dbg_gnt=1, rom_ce=0 each time; next cycle dbg_rvalid=1, dbg_err=1, dbg_rdata=0.
- Assert rst=0 asynchronously the cycle after a grant -> if_rvalid=0, if_rdata=0, wait_cnt=0 immediately; no response appears after release.
- Only dbg_req with if_req=0 -> immediate dbg_gnt every cycle; wait_cnt stays 0.
